// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Single-word SPI slave. It is the responder end of the team's SPI master. It
// uses the same CPOL/CPHA conventions, and words go MSB first. Every SPI pin is
// brought into the system clock domain through a synchronizer chain, so no
// logic is clocked by sclk.
//
// Parameters
//   DATA_WIDTH   bits per frame (>= 2)
//   CPOL         idle level of sclk
//   CPHA         clock phase (0: sample on leading edge, 1: sample on trailing)
//   SYNC_STAGES  synchronizer depth for sclk/csn/mosi (>= 2)
//
// Ports
//   clk          system clock (rising edge)
//   arstn        asynchronous active-low reset
//   sclk         SPI clock from the master (asynchronous)
//   csn          chip select, active low (asynchronous)
//   mosi         master-out serial data (asynchronous)
//   miso         slave-out serial data, MSB first
//   miso_oe      pad output enable; high while a frame is active
//   data_send    word to transmit, latched when the frame starts
//   data_recv    last complete received word, held until the next one
//   recv_valid   one-cycle pulse when data_recv has just been updated
//   busy         high from frame start until csn deassert is detected
//   frame_err    one-cycle pulse when csn rises with a partial word
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int   DATA_WIDTH  = 8,
    parameter logic CPOL        = 1'b1,
    parameter logic CPHA        = 1'b1,
    parameter int   SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  sclk,
    input  logic                  csn,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] data_send,
    output logic [DATA_WIDTH-1:0] data_recv,
    output logic                  recv_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer chains and edge-detect history
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_hist_q;
    logic                   csn_hist_q;

    // Synchronizer shift chains. csn resets low so that a master already
    // holding csn low is not mistaken for a fresh frame start.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            sclk_hist_q <= CPOL;
            csn_sync_q  <= {SYNC_STAGES{1'b0}};
            csn_hist_q  <= 1'b0;
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
            csn_hist_q  <= csn_sync_q[SYNC_STAGES-1];
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    logic sclk_s;
    logic csn_s;
    logic mosi_s;
    logic lead_edge_s;
    logic trail_edge_s;
    logic sample_edge_s;
    logic shift_edge_s;
    logic csn_fall_s;
    logic csn_rise_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Leading edge leaves the idle level and trailing edge returns to it.
    assign lead_edge_s  = (sclk_hist_q == CPOL) && (sclk_s != CPOL);
    assign trail_edge_s = (sclk_hist_q != CPOL) && (sclk_s == CPOL);

    assign sample_edge_s = (CPHA == 1'b1) ? trail_edge_s : lead_edge_s;
    assign shift_edge_s  = (CPHA == 1'b1) ? lead_edge_s  : trail_edge_s;

    assign csn_fall_s = csn_hist_q  && !csn_s;
    assign csn_rise_s = !csn_hist_q && csn_s;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t                state_q,      state_d;
    logic [DATA_WIDTH-1:0] tx_shift_q,   tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q,   rx_shift_d;
    logic [CW-1:0]         bit_cnt_q,    bit_cnt_d;
    logic                  first_q,      first_d;
    logic [DATA_WIDTH-1:0] data_recv_q,  data_recv_d;
    logic                  recv_valid_q, recv_valid_d;
    logic                  frame_err_q,  frame_err_d;
    logic                  busy_q,       busy_d;
    logic                  miso_q,       miso_d;

    // Next-state and datapath logic for the frame FSM.
    always_comb begin
        state_d      = state_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        first_d      = first_q;
        data_recv_d  = data_recv_q;
        recv_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // sclk edges coinciding with the csn fall are ignored here.
                if (csn_fall_s) begin
                    state_d    = ST_SHIFT;
                    tx_shift_d = data_send;
                    bit_cnt_d  = CNT_ZERO;
                    first_d    = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                // csn rise has priority: a coincident sample is dropped.
                if (csn_rise_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != CNT_ZERO);
                end else if (sample_edge_s) begin
                    // Truncating cast drops the oldest bit off the top.
                    rx_shift_d = DATA_WIDTH'({rx_shift_q, mosi_s});
                    bit_cnt_d  = bit_cnt_q + CNT_ONE;
                    if (bit_cnt_q == CNT_LAST) begin
                        data_recv_d  = rx_shift_d;
                        recv_valid_d = 1'b1;
                        state_d      = ST_FULL;
                    end else begin
                        state_d      = ST_SHIFT;
                    end
                end else if (shift_edge_s) begin
                    // With CPHA=1 the MSB is already driven at frame start,
                    // so the first leading edge must not advance the word.
                    if ((CPHA == 1'b1) && first_q) begin
                        first_d    = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end

            ST_FULL: begin
                // Overrun edges are ignored; only the frame end matters.
                if (csn_rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FULL;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered output values derived from the next state.
    always_comb begin
        miso_d = tx_shift_d[DATA_WIDTH-1];
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= ST_IDLE;
            tx_shift_q   <= {DATA_WIDTH{1'b0}};
            rx_shift_q   <= {DATA_WIDTH{1'b0}};
            bit_cnt_q    <= CNT_ZERO;
            first_q      <= 1'b0;
            data_recv_q  <= {DATA_WIDTH{1'b0}};
            recv_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            miso_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            first_q      <= first_d;
            data_recv_q  <= data_recv_d;
            recv_valid_q <= recv_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            miso_q       <= miso_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = busy_q;
    assign busy       = busy_q;
    assign data_recv  = data_recv_q;
    assign recv_valid = recv_valid_q;
    assign frame_err  = frame_err_q;

endmodule
